// File: rtl/elastic_pipe_reg_pkg.sv
// Shared types and sizing helpers for the elastic pipeline register.
package elastic_pipe_reg_pkg;

  typedef enum logic [2:0] {
    MV_HOLD         = 3'd0,
    MV_SKID_TO_MAIN = 3'd1,
    MV_IN_TO_MAIN   = 3'd2,
    MV_DRAIN        = 3'd3,
    MV_IN_TO_SKID   = 3'd4,
    MV_FLUSH        = 3'd5
  } slice_move_e;

  // Occupancy counter width able to hold 0..2*nr_stage.
  function automatic int occ_width(input int nr_stage);
    return $clog2(2 * nr_stage + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_slice.sv
// One elastic slice: a main entry plus a skid entry so upstream ready can be
// a pure register output while still sustaining one transfer per cycle.
module elastic_pipe_reg_slice
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic             main_v,
  output logic             skid_v
);

  logic             main_v_r;
  logic [WIDTH-1:0] main_d_r;
  logic             skid_v_r;
  logic [WIDTH-1:0] skid_d_r;
  logic             acc_s;
  logic             take_s;
  slice_move_e      move_s;

  assign up_ready = !skid_v_r;
  assign dn_valid = main_v_r;
  assign dn_data  = main_d_r;
  assign main_v   = main_v_r;
  assign skid_v   = skid_v_r;

  // Decode which register move happens at the next edge.
  always_comb begin
    acc_s  = up_valid && !skid_v_r;
    take_s = main_v_r && dn_ready;
    move_s = MV_HOLD;
    if (flush) begin
      move_s = MV_FLUSH;
    end else if (!main_v_r || take_s) begin
      if (skid_v_r) begin
        move_s = MV_SKID_TO_MAIN;
      end else if (acc_s) begin
        move_s = MV_IN_TO_MAIN;
      end else begin
        move_s = MV_DRAIN;
      end
    end else if (acc_s) begin
      move_s = MV_IN_TO_SKID;
    end else begin
      move_s = MV_HOLD;
    end
  end

  // Slice state; data registers only load on an actual move to avoid idle toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_r <= 1'b0;
      main_d_r <= RESET_VAL;
      skid_v_r <= 1'b0;
      skid_d_r <= RESET_VAL;
    end else begin
      case (move_s)
        MV_FLUSH: begin
          main_v_r <= 1'b0;
          main_d_r <= RESET_VAL;
          skid_v_r <= 1'b0;
          skid_d_r <= RESET_VAL;
        end
        MV_SKID_TO_MAIN: begin
          main_v_r <= 1'b1;
          main_d_r <= skid_d_r;
          skid_v_r <= 1'b0;
        end
        MV_IN_TO_MAIN: begin
          main_v_r <= 1'b1;
          main_d_r <= up_data;
          skid_v_r <= 1'b0;
        end
        MV_DRAIN: begin
          main_v_r <= 1'b0;
          skid_v_r <= 1'b0;
        end
        MV_IN_TO_SKID: begin
          skid_v_r <= 1'b1;
          skid_d_r <= up_data;
        end
        default: begin
          main_v_r <= main_v_r;
          skid_v_r <= skid_v_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Chain of NR_STAGE elastic slices for inter-stage links that must stall
// without losing data and drop in-flight payloads on flush.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NR_STAGE  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [occ_width(NR_STAGE)-1:0] occupancy
);

  localparam int OCC_W = occ_width(NR_STAGE);

  if (NR_STAGE < 1) begin : g_bad_nr_stage
    $error("elastic_pipe_reg: NR_STAGE must be at least 1");
  end

  logic [NR_STAGE:0]   vld_s;
  logic [NR_STAGE:0]   rdy_s;
  logic [WIDTH-1:0]    dat_s [NR_STAGE+1];
  logic [NR_STAGE-1:0] main_v_s;
  logic [NR_STAGE-1:0] skid_v_s;
  logic [OCC_W-1:0]    occ_s;

  assign vld_s[0]        = in_valid;
  assign dat_s[0]        = in_data;
  assign in_ready        = rdy_s[0];
  assign out_valid       = vld_s[NR_STAGE];
  assign out_data        = dat_s[NR_STAGE];
  assign rdy_s[NR_STAGE] = out_ready;

  for (genvar i = 0; i < NR_STAGE; i++) begin : g_slice
    elastic_pipe_reg_slice #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (vld_s[i]),
      .up_ready (rdy_s[i]),
      .up_data  (dat_s[i]),
      .dn_valid (vld_s[i+1]),
      .dn_ready (rdy_s[i+1]),
      .dn_data  (dat_s[i+1]),
      .main_v   (main_v_s[i]),
      .skid_v   (skid_v_s[i])
    );
  end

  // Popcount of every held entry across all slices.
  always_comb begin
    occ_s = {OCC_W{1'b0}};
    for (int i = 0; i < NR_STAGE; i++) begin
      occ_s = occ_s + OCC_W'(main_v_s[i]) + OCC_W'(skid_v_s[i]);
    end
  end

  assign occupancy = occ_s;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed and randomised checks of elastic_pipe_reg over several depths/widths.
module tb_elastic_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic ir1, ov1, ir2, ov2, ir3, ov3, ir4, ov4, irw, ovw, odw;
  logic [7:0] od1, od2, od3, od4;
  logic [1:0] oc1, ocw;
  logic [2:0] oc2, oc3;
  logic [3:0] oc4;

  int n_checks = 0;
  int n_fail   = 0;

  elastic_pipe_reg #(.WIDTH(8), .NR_STAGE(1), .RESET_VAL(8'h5A)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(oc1));
  elastic_pipe_reg #(.WIDTH(8), .NR_STAGE(2), .RESET_VAL(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(oc2));
  elastic_pipe_reg #(.WIDTH(8), .NR_STAGE(3), .RESET_VAL(8'h5A)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(oc3));
  elastic_pipe_reg #(.WIDTH(8), .NR_STAGE(4), .RESET_VAL(8'h5A)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .occupancy(oc4));
  elastic_pipe_reg #(.WIDTH(1), .NR_STAGE(1), .RESET_VAL(1'b1)) dutw (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(irw), .in_data(in_data[0]),
    .out_valid(ovw), .out_ready(out_ready), .out_data(odw), .occupancy(ocw));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q1[$];
  logic [7:0] q4[$];
  logic       stall1, stall4;
  logic [7:0] st_d1, st_d4;
  int         acc;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", ir3, 1);
    check_eq("rst_out_valid", ov3, 0);
    check_eq("rst_out_data", od3, 8'h5A);
    check_eq("rst_occ3", oc3, 0);
    check_eq("rst_occ4", oc4, 0);
    check_eq("rst_w1_data", odw, 1);
    check_eq("rst_w1_valid", ovw, 0);
    check_eq("rst_w1_ready", irw, 1);
    check_eq("rst_w1_occ", ocw, 0);
    rst = 1'b0;
    tick();

    // Streaming through three slices: data k+1 presented in cycle k.
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      in_valid = (c < 20);
      in_data  = 8'(c + 1);
      check_eq("stream_in_ready", ir3, 1);
      tick();
      check_eq("stream_valid", ov3, (c >= 2 && c <= 21));
      if (c >= 2 && c <= 21) check_eq("stream_data", od3, c - 1);
    end
    in_valid = 1'b0;
    repeat (10) tick();

    // Backpressure on two slices: capacity four.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_data = 8'(8'hA0 + acc);
      check_eq("bp_in_ready", ir2, (k < 4));
      if (ir2) acc++;
      tick();
      check_eq("bp_occ", oc2, (k < 4) ? k + 1 : 4);
    end
    check_eq("bp_accepted", acc, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      check_eq("bp_out_valid", ov2, (r < 4));
      if (r < 4) check_eq("bp_out_data", od2, 8'hA0 + r);
      tick();
      check_eq("bp_in_ready_release", ir2, (r >= 1));
    end
    repeat (12) tick();

    // Flush with entries held and a new payload offered in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'h10 + k);
      tick();
    end
    check_eq("fl_pre_occ2", oc2, 4);
    check_eq("fl_pre_occ3", oc3, 4);
    check_eq("fl_pre_ready3", ir3, 1);
    flush   = 1'b1;
    in_data = 8'h55;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_valid2", ov2, 0);
    check_eq("fl_occ2", oc2, 0);
    check_eq("fl_valid3", ov3, 0);
    check_eq("fl_occ3", oc3, 0);
    check_eq("fl_data3", od3, 8'h5A);
    check_eq("fl_w1_data", odw, 1);
    check_eq("fl_ready2", ir2, 1);
    check_eq("fl_ready3", ir3, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("fl_no_55_d3", ov3, 0);
      check_eq("fl_no_55_d2", ov2, 0);
    end

    // Asynchronous reset with three entries held, checked before any edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'h31 + k);
      tick();
    end
    in_valid = 1'b0;
    check_eq("ar_pre_occ3", oc3, 3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", ov3, 0);
    check_eq("ar_occ", oc3, 0);
    check_eq("ar_data", od3, 8'h5A);
    check_eq("ar_ready", ir3, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Random traffic against a queue scoreboard for depths 1 and 4.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 3);
      in_data   = 8'($urandom);
      #1;
      if (in_valid && ir1) q1.push_back(in_data);
      if (in_valid && ir4) q4.push_back(in_data);
      if (ov1 && out_ready) begin
        if (q1.size() == 0) check_eq("rnd1_spurious", 1, 0);
        else check_eq("rnd1_data", od1, q1.pop_front());
      end
      if (ov4 && out_ready) begin
        if (q4.size() == 0) check_eq("rnd4_spurious", 1, 0);
        else check_eq("rnd4_data", od4, q4.pop_front());
      end
      stall1 = ov1 && !out_ready;
      stall4 = ov4 && !out_ready;
      st_d1  = od1;
      st_d4  = od4;
      tick();
      check_eq("rnd1_occ", oc1, q1.size());
      check_eq("rnd4_occ", oc4, q4.size());
      if (stall1) begin
        check_eq("rnd1_stall_valid", ov1, 1);
        check_eq("rnd1_stall_data", od1, st_d1);
      end
      if (stall4) begin
        check_eq("rnd4_stall_valid", ov4, 1);
        check_eq("rnd4_stall_data", od4, st_d4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
